// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter: shares one WIDTH-bit D/Q/Qn register among four
// requesters using round-robin arbitration.
//
// A write is a three-state sequence:
//   IDLE -> GRANT   pick a winner starting from the rotating pointer
//   GRANT -> ACK    latch the owner's data into Q and pulse Ack
//                   (if the owner drops Req, abort back to IDLE instead)
//   ACK -> IDLE     advance the pointer past the owner
//
// Ports:
//   Clk, Rst_n         clock; asynchronous active-low reset
//   Req[3:0]           level requests, bit i = requester i
//   D0..D3             per-requester write data
//   Gnt[3:0]           registered one-hot grant
//   Ack[3:0]           registered one-hot write acknowledge (one-cycle pulse)
//   Q, Qn              shared register contents and their complement
//   Busy               high while not in IDLE
//   Owner[1:0]         index of the current/last grant
module reg_share_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [3:0]       Req,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic [WIDTH-1:0] D3,
  output logic [3:0]       Gnt,
  output logic [3:0]       Ack,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic             Busy,
  output logic [1:0]       Owner
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_ACK} state_e;

  state_e                state_q, state_d;
  logic [3:0]            gnt_q, gnt_d;
  logic [3:0]            ack_q, ack_d;
  logic [WIDTH-1:0]      q_q, q_d;
  logic                  busy_q, busy_d;
  logic [1:0]            owner_q, owner_d;
  logic [1:0]            ptr_q, ptr_d;

  logic [3:0][WIDTH-1:0] d_arr;
  logic [1:0]            sel;
  logic [1:0]            idx;

  assign d_arr = {D3, D2, D1, D0};

  // Round-robin pick: scan from the farthest position back toward the
  // pointer so the last match (the nearest one to ptr_q) wins.
  always_comb begin
    sel = ptr_q;
    idx = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (Req[idx]) sel = idx;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ack_d   = ack_q;
    q_d     = q_q;
    busy_d  = busy_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      S_IDLE: begin
        if (|Req) begin
          state_d = S_GRANT;
          gnt_d   = 4'b0001 << sel;
          owner_d = sel;
          busy_d  = 1'b1;
        end
      end
      S_GRANT: begin
        if (Req[owner_q]) begin
          state_d = S_ACK;
          q_d     = d_arr[owner_q];
          ack_d   = 4'b0001 << owner_q;
        end else begin
          // Owner withdrew: no write, pointer stays so it is not penalised.
          state_d = S_IDLE;
          gnt_d   = 4'b0000;
          busy_d  = 1'b0;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        ptr_d   = owner_q + 2'd1;
        gnt_d   = 4'b0000;
        ack_d   = 4'b0000;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 4'b0000;
        ack_d   = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      q_q     <= '0;
      busy_q  <= 1'b0;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  assign Gnt   = gnt_q;
  assign Ack   = ack_q;
  assign Q     = q_q;
  assign Qn    = ~q_q;
  assign Busy  = busy_q;
  assign Owner = owner_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Bench for reg_share_arbiter: a transaction-level reference (phase,
// pointer, owner, stored value) is advanced on every clock and compared
// with the DUT on every falling edge; directed scenarios add literal checks.
module tb_reg_share_arbiter;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b1;
  logic [3:0] Req = 4'b0000;
  logic [7:0] D0 = 8'h00, D1 = 8'h00, D2 = 8'h00, D3 = 8'h00;
  logic [3:0] Gnt, Ack;
  logic [7:0] Q, Qn;
  logic       Busy;
  logic [1:0] Owner;

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;

  reg_share_arbiter #(.WIDTH(8)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Req(Req),
    .D0(D0), .D1(D1), .D2(D2), .D3(D3),
    .Gnt(Gnt), .Ack(Ack), .Q(Q), .Qn(Qn), .Busy(Busy), .Owner(Owner)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc_cnt++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: phase 0 = waiting, 1 = granted, 2 = written/acknowledged.
  int         m_phase = 0;
  int         m_ptr = 0;
  int         m_owner = 0;
  logic [7:0] m_q = 8'h00;

  function automatic logic [7:0] dsel(input int i);
    case (i)
      0: return D0;
      1: return D1;
      2: return D2;
      default: return D3;
    endcase
  endfunction

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      m_phase = 0; m_ptr = 0; m_owner = 0; m_q = 8'h00;
    end else begin
      if (m_phase == 0) begin
        if (Req != 4'b0000) begin
          for (int k = 0; k < 4; k++)
            if (Req[(m_ptr + k) % 4]) begin
              m_owner = (m_ptr + k) % 4;
              break;
            end
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (Req[m_owner]) begin
          m_q = dsel(m_owner);
          m_phase = 2;
        end else m_phase = 0;
      end else begin
        m_ptr = (m_owner + 1) % 4;
        m_phase = 0;
      end
    end
  end

  always @(negedge Clk) begin
    chk("model_gnt",   {28'd0, Gnt},   (m_phase != 0) ? (32'd1 << m_owner) : 32'd0);
    chk("model_ack",   {28'd0, Ack},   (m_phase == 2) ? (32'd1 << m_owner) : 32'd0);
    chk("model_q",     {24'd0, Q},     {24'd0, m_q});
    chk("model_qn",    {24'd0, Qn},    {24'd0, ~m_q});
    chk("model_busy",  {31'd0, Busy},  {31'd0, m_phase != 0});
    chk("model_owner", {30'd0, Owner}, 32'(m_owner));
  end

  task automatic cyc();
    @(negedge Clk);
  endtask

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      if (Ack != 4'b0000) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL ack_timeout actual=none required=ack within 8 cycles at %0t", $time);
    end
  endtask

  initial begin
    int  exp_own [5] = '{0, 1, 2, 3, 0};
    int  exp_q   [5] = '{'h10, 'h21, 'h32, 'h43, 'h10};
    int  last_ack;
    bit  ok;

    // Reset asserted mid-cycle with all requests high.
    Req = 4'b1111;
    D0 = 8'h10; D1 = 8'h21; D2 = 8'h32; D3 = 8'h43;
    #2 Rst_n = 1'b0;
    #1;
    chk("rst_gnt", {28'd0, Gnt}, 32'h0);
    chk("rst_ack", {28'd0, Ack}, 32'h0);
    chk("rst_q", {24'd0, Q}, 32'h00);
    chk("rst_qn", {24'd0, Qn}, 32'hFF);
    chk("rst_busy", {31'd0, Busy}, 32'h0);
    chk("rst_owner", {30'd0, Owner}, 32'h0);
    cyc(); cyc();
    chk("rst_hold_gnt", {28'd0, Gnt}, 32'h0);
    Rst_n = 1'b1;

    // Full contention: 0,1,2,3,0, one write every 3 cycles.
    last_ack = 0;
    for (int i = 0; i < 5; i++) begin
      wait_ack(ok);
      if (ok) begin
        chk("cont_owner", {30'd0, Owner}, 32'(exp_own[i]));
        chk("cont_q", {24'd0, Q}, 32'(exp_q[i]));
        if (i > 0) chk("cont_spacing", 32'(cyc_cnt - last_ack), 32'd3);
        last_ack = cyc_cnt;
      end
    end
    Req = 4'b0000;
    cyc();

    // Withdrawal during GRANT, then 0011 must still pick requester 1.
    Req = 4'b0010;
    cyc();
    chk("wd_gnt", {28'd0, Gnt}, 32'h2);
    Req = 4'b0000;
    cyc();
    chk("wd_abort_gnt", {28'd0, Gnt}, 32'h0);
    chk("wd_abort_ack", {28'd0, Ack}, 32'h0);
    chk("wd_abort_busy", {31'd0, Busy}, 32'h0);
    chk("wd_abort_q", {24'd0, Q}, 32'h10);
    Req = 4'b0011;
    cyc();
    chk("wd_regrant", {30'd0, Owner}, 32'd1);
    cyc();
    chk("wd_q", {24'd0, Q}, 32'h21);
    Req = 4'b0000;
    cyc();

    // Single request to requester 2.
    D2 = 8'hA5;
    Req = 4'b0100;
    cyc();
    chk("single_gnt", {28'd0, Gnt}, 32'h4);
    chk("single_owner", {30'd0, Owner}, 32'd2);
    chk("single_q_before", {24'd0, Q}, 32'h21);
    cyc();
    chk("single_q", {24'd0, Q}, 32'hA5);
    chk("single_qn", {24'd0, Qn}, 32'h5A);
    chk("single_ack", {28'd0, Ack}, 32'h4);
    Req = 4'b0000;
    cyc();
    chk("single_done_gnt", {28'd0, Gnt}, 32'h0);
    chk("single_done_ack", {28'd0, Ack}, 32'h0);
    chk("single_done_busy", {31'd0, Busy}, 32'h0);

    // Rotation/wrap: 3 completes, then 1001 gives 0 then 3.
    Req = 4'b1000;
    cyc(); cyc();
    chk("rot3_q", {24'd0, Q}, 32'h43);
    Req = 4'b1001;
    cyc(); cyc();
    chk("rot_wrap_owner", {30'd0, Owner}, 32'd0);
    cyc();
    chk("rot_wrap_q", {24'd0, Q}, 32'h10);
    cyc(); cyc();
    chk("rot_next_owner", {30'd0, Owner}, 32'd3);
    cyc();
    Req = 4'b0000;
    cyc();

    // Reset in the middle of ACK.
    D0 = 8'h77;
    Req = 4'b0001;
    cyc(); cyc();
    chk("mid_ack_seen", {28'd0, Ack}, 32'h1);
    chk("mid_q_seen", {24'd0, Q}, 32'h77);
    #2 Rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", {28'd0, Ack}, 32'h0);
    chk("mid_rst_gnt", {28'd0, Gnt}, 32'h0);
    chk("mid_rst_q", {24'd0, Q}, 32'h00);
    chk("mid_rst_qn", {24'd0, Qn}, 32'hFF);
    chk("mid_rst_busy", {31'd0, Busy}, 32'h0);
    Req = 4'b1100;
    cyc();
    Rst_n = 1'b1;
    cyc();
    chk("post_rst_gnt", {28'd0, Gnt}, 32'h4);
    chk("post_rst_owner", {30'd0, Owner}, 32'd2);
    cyc();
    chk("post_rst_q", {24'd0, Q}, 32'hA5);
    Req = 4'b0000;
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
